// File: rtl/fdb_doorbell_queue_if.sv
// Ring (producer) and pop (consumer) handshake bundle for fdb_doorbell_queue.
// The master drives rings and pop_ready; the slave is the queue itself.
interface fdb_doorbell_queue_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PRIO_W = 2
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              ring_valid;
  logic [CH_W-1:0]   ring_ch;
  logic [PRIO_W-1:0] ring_prio;
  logic [DATA_W-1:0] ring_data;
  logic              ring_fail;

  logic              pop_valid;
  logic              pop_ready;
  logic [CH_W-1:0]   pop_ch;
  logic [PRIO_W-1:0] pop_prio;
  logic [DATA_W-1:0] pop_data;
  logic              pop_empty;

  modport master (
    output ring_valid, ring_ch, ring_prio, ring_data, pop_ready,
    input  ring_fail, pop_valid, pop_ch, pop_prio, pop_data, pop_empty
  );

  modport slave (
    input  ring_valid, ring_ch, ring_prio, ring_data, pop_ready,
    output ring_fail, pop_valid, pop_ch, pop_prio, pop_data, pop_empty
  );
endinterface

// File: rtl/fdb_doorbell_queue.sv
// Multi-channel doorbell queue: per-channel FIFOs with pending-max priority,
// single consumer served highest-priority first, round-robin among equals.
module fdb_doorbell_queue #(
  parameter  int unsigned NUM_CH = 4,
  parameter  int unsigned DEPTH  = 8,
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned PRIO_W = 2,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  fdb_doorbell_queue_if.slave      bus,
  input  logic [NUM_CH-1:0]        ch_enable,
  input  logic                     ack_on_empty,
  output logic [NUM_CH*CNT_W-1:0]  fill_cnt,
  output logic [NUM_CH*PRIO_W-1:0] max_priority,
  output logic [NUM_CH-1:0]        failed_ring,
  input  logic [NUM_CH-1:0]        failed_clr
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [NUM_CH];
  logic [PTR_W-1:0]  wr_ptr_d [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr_q [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  cnt_d    [NUM_CH];
  logic [PRIO_W-1:0] maxp_q   [NUM_CH];
  logic [PRIO_W-1:0] maxp_d   [NUM_CH];
  logic [NUM_CH-1:0] failed_q, failed_d;
  logic              ring_fail_q, ring_fail_d;
  logic [CH_W-1:0]   rr_q, rr_d;

  logic [NUM_CH-1:0] elig;
  logic              any_elig;
  logic [PRIO_W-1:0] best_prio;
  logic [CH_W-1:0]   sel;
  logic [CH_W-1:0]   scan_idx;
  logic              found;

  logic              ch_ok;
  logic [CH_W-1:0]   rch;
  logic              ring_acc;
  logic              ring_rej;
  logic              pop_fire;
  logic [NUM_CH-1:0] wr_en;
  logic [NUM_CH-1:0] rd_en;

  // Selection depends only on registered state plus ch_enable/ack_on_empty.
  always_comb begin
    elig      = '0;
    best_prio = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      elig[i] = ch_enable[i] && (cnt_q[i] != '0);
      if (elig[i] && (maxp_q[i] > best_prio)) best_prio = maxp_q[i];
    end
    any_elig = |elig;

    sel      = '0;
    scan_idx = '0;
    found    = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      scan_idx = CH_W'((32'(rr_q) + k) % NUM_CH);
      if (!found && elig[scan_idx] && (maxp_q[scan_idx] == best_prio)) begin
        found = 1'b1;
        sel   = scan_idx;
      end
    end

    bus.pop_valid = any_elig | ack_on_empty;
    bus.pop_empty = !any_elig & ack_on_empty;
    bus.pop_ch    = any_elig ? sel : '0;
    bus.pop_prio  = any_elig ? maxp_q[sel] : '0;
    bus.pop_data  = any_elig ? mem_q[sel][rd_ptr_q[sel]] : '0;
  end

  // Fullness is judged on the pre-pop count, so a same-cycle pop never frees a slot.
  always_comb begin
    ch_ok    = 32'(bus.ring_ch) < NUM_CH;
    rch      = ch_ok ? bus.ring_ch : '0;
    ring_acc = bus.ring_valid && ch_ok && ch_enable[rch] && (32'(cnt_q[rch]) < DEPTH);
    ring_rej = bus.ring_valid && !ring_acc;
    pop_fire = any_elig && bus.pop_ready;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    maxp_d      = maxp_q;
    rr_d        = rr_q;
    wr_en       = '0;
    rd_en       = '0;
    ring_fail_d = ring_rej;
    failed_d    = failed_q & ~failed_clr;
    if (ring_rej && ch_ok) failed_d[rch] = 1'b1;

    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_en[i] = ring_acc && (rch == CH_W'(i));
      rd_en[i] = pop_fire && (sel == CH_W'(i));
      if (wr_en[i]) wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
      if (rd_en[i]) rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
      if (wr_en[i] && !rd_en[i])      cnt_d[i] = cnt_q[i] + CNT_W'(1);
      else if (rd_en[i] && !wr_en[i]) cnt_d[i] = cnt_q[i] - CNT_W'(1);
      // Draining the last entry resets the pending max; a same-cycle ring replaces it.
      if (rd_en[i] && (cnt_q[i] == CNT_W'(1)))
        maxp_d[i] = wr_en[i] ? bus.ring_prio : '0;
      else if (wr_en[i] && (bus.ring_prio > maxp_q[i]))
        maxp_d[i] = bus.ring_prio;
    end

    if (pop_fire) rr_d = CH_W'((32'(sel) + 1) % NUM_CH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
        maxp_q[i]   <= '0;
      end
      failed_q    <= '0;
      ring_fail_q <= 1'b0;
      rr_q        <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      maxp_q      <= maxp_d;
      failed_q    <= failed_d;
      ring_fail_q <= ring_fail_d;
      rr_q        <= rr_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (wr_en[i]) mem_q[i][wr_ptr_q[i]] <= bus.ring_data;
    end
  end

  always_comb begin
    fill_cnt     = '0;
    max_priority = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      fill_cnt[i*CNT_W +: CNT_W]      = cnt_q[i];
      max_priority[i*PRIO_W +: PRIO_W] = maxp_q[i];
    end
  end

  assign failed_ring   = failed_q;
  assign bus.ring_fail = ring_fail_q;
endmodule
